// File: rtl/slot_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : slot_decoder_if
// Description : Command and status bundle for slot_decoder (err_o present only
//               when SLOT_DECODER_ERR_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
interface slot_decoder_if #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 1 << WIDTH-1
);
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [1:0]       cmd_op_i;
    logic [WIDTH-1:0] cmd_index_i;
    logic [DEPTH-1:0] onehot_o;
    logic             done_o;
    logic [DEPTH-1:0] valid_vec_o;
    logic [WIDTH-1:0] count_o;
    logic             full_o;
    logic             empty_o;

`ifdef SLOT_DECODER_ERR_EN
    logic             err_o;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_index_i,
        input  cmd_ready_o, onehot_o, done_o, valid_vec_o, count_o, full_o, empty_o, err_o
    );
    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_index_i,
        output cmd_ready_o, onehot_o, done_o, valid_vec_o, count_o, full_o, empty_o, err_o
    );
`else
    modport master (
        output cmd_valid_i, cmd_op_i, cmd_index_i,
        input  cmd_ready_o, onehot_o, done_o, valid_vec_o, count_o, full_o, empty_o
    );
    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_index_i,
        output cmd_ready_o, onehot_o, done_o, valid_vec_o, count_o, full_o, empty_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/slot_decoder.sv
`default_nettype none
// ============================================================================
// Module      : slot_decoder
// Description : Three-state slot set/clear decoder with occupancy vector and
//               count. Optional sticky err_o under macro SLOT_DECODER_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_decoder #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 1 << WIDTH-1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    slot_decoder_if.slave bus
);
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_decode  = 2'd1;
    localparam logic [1:0] c_st_commit  = 2'd2;

    localparam logic [1:0] c_op_nop     = 2'b00;
    localparam logic [1:0] c_op_set     = 2'b01;
    localparam logic [1:0] c_op_clr     = 2'b10;
    localparam logic [1:0] c_op_clr_all = 2'b11;

    localparam logic [WIDTH:0]   c_depth      = (WIDTH+1)'(DEPTH);
    localparam logic [DEPTH-1:0] c_onehot_lsb = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_count_inc  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             w_accept;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_index;
    logic [DEPTH-1:0] r_onehot;
    logic [DEPTH-1:0] r_valid_vec;
    logic [WIDTH-1:0] r_count;
    logic             r_done;
    logic             w_in_range;
    logic             w_hit;
    logic [DEPTH-1:0] w_decode;
    logic [DEPTH-1:0] w_vec_next;
    logic [WIDTH-1:0] w_count_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.cmd_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = c_st_decode;
                end
            end
            c_st_decode: w_state_next = c_st_commit;
            c_st_commit: w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    // w_hit is only meaningful in COMMIT, where r_onehot belongs to the captured command
    always_comb begin
        w_in_range   = ({1'b0, r_index} < c_depth);
        w_hit        = |(r_valid_vec & r_onehot);
        w_decode     = '0;
        if (r_op == c_op_clr_all) begin
            w_decode = '1;
        end else if (w_in_range) begin
            w_decode = c_onehot_lsb << r_index;
        end
        w_vec_next   = r_valid_vec;
        w_count_next = r_count;
        case (r_op)
            c_op_nop: begin
                w_vec_next = r_valid_vec;
            end
            c_op_set: begin
                w_vec_next = r_valid_vec | r_onehot;
                if ((|r_onehot) && !w_hit) w_count_next = r_count + c_count_inc;
            end
            c_op_clr: begin
                w_vec_next = r_valid_vec & ~r_onehot;
                if (w_hit) w_count_next = r_count - c_count_inc;
            end
            default: begin
                w_vec_next   = '0;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op        <= c_op_nop;
            r_index     <= '0;
            r_onehot    <= '0;
            r_valid_vec <= '0;
            r_count     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == c_st_commit);
            if (w_accept) begin
                r_op    <= bus.cmd_op_i;
                r_index <= bus.cmd_index_i;
            end
            if (r_state == c_st_decode) begin
                r_onehot <= w_decode;
            end
            if (r_state == c_st_commit) begin
                r_valid_vec <= w_vec_next;
                r_count     <= w_count_next;
            end
        end
    end

    assign bus.cmd_ready_o = (r_state == c_st_idle);
    assign bus.onehot_o    = r_onehot;
    assign bus.done_o      = r_done;
    assign bus.valid_vec_o = r_valid_vec;
    assign bus.count_o     = r_count;
    assign bus.full_o      = ({1'b0, r_count} == c_depth);
    assign bus.empty_o     = (r_count == '0);

`ifdef SLOT_DECODER_ERR_EN
    logic w_err_evt;
    logic r_err;

    always_comb begin
        w_err_evt = 1'b0;
        if (r_op == c_op_set) begin
            w_err_evt = !w_in_range || w_hit;
        end else if (r_op == c_op_clr) begin
            w_err_evt = !w_in_range || !w_hit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if ((r_state == c_st_commit) && w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_o = r_err;
`endif
endmodule
`default_nettype wire

// File: doc/slot_decoder.md
SLOT_DECODER -- requirements
Module: slot_decoder

Interface
REQ-001 Parameter WIDTH, default 6, SHALL be the index width.
REQ-002 Parameter DEPTH, default 1<<WIDTH-1 (32), SHALL be the number of slots.
REQ-003 clk_i  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 cmd_valid_i  in  1  SHALL indicate that a command is offered.
REQ-006 cmd_ready_o  out  1  SHALL indicate that the block accepts a command this cycle.
REQ-007 cmd_op_i  in  2  SHALL select the operation: 00 nop, 01 set slot, 10 clear slot, 11 clear-all.
REQ-008 cmd_index_i  in  WIDTH  SHALL carry the slot index; values >= DEPTH (e.g. miss code 32) are out of range.
REQ-009 onehot_o  out  DEPTH  SHALL be the registered one-hot decode of the accepted index.
REQ-010 done_o  out  1  SHALL be a one-cycle pulse marking command completion.
REQ-011 valid_vec_o  out  DEPTH  SHALL be the slot occupancy vector; bit i high means slot i is occupied.
REQ-012 count_o  out  WIDTH  SHALL be the number of occupied slots, 0..DEPTH.
REQ-013 full_o / empty_o  out  1 each  SHALL indicate count_o==DEPTH and count_o==0 respectively.

Function
REQ-014 The FSM SHALL have three states, IDLE -> DECODE -> COMMIT -> IDLE, with one cycle per state.
REQ-015 cmd_ready_o SHALL be 1 only in IDLE; a command SHALL be accepted only when cmd_valid_i and cmd_ready_o are both high at a clock edge.
REQ-016 On accept, op and index SHALL be captured; later changes to the inputs SHALL have no effect on that command.
REQ-017 DECODE: onehot_o SHALL be loaded as follows: bit[index]=1 if index<DEPTH, all zero if index>=DEPTH, all ones for clear-all.
REQ-018 COMMIT: valid_vec_o SHALL be updated at the edge leaving COMMIT, as follows:
- set: OR with onehot_o
- clear: AND with ~onehot_o
- clear-all: all zero
- nop: no change
REQ-019 For a command accepted at edge T, onehot_o SHALL be valid from T+1, and valid_vec_o, count_o, full_o and empty_o SHALL reflect the update from T+2.
REQ-020 For the same command, done_o SHALL be high for exactly the cycle after T+2, which coincides with cmd_ready_o=1.
REQ-021 Throughput SHALL be one command per 3 cycles; back-to-back valid SHALL therefore be accepted every third edge.
REQ-022 count_o SHALL equal the popcount of valid_vec_o in every cycle.
REQ-023 Set of an occupied slot, or clear of a free slot, SHALL leave valid_vec_o and count_o unchanged.
REQ-024 An out-of-range index SHALL leave valid_vec_o unchanged and SHALL still complete with a done_o pulse.
REQ-025 Set while full_o=1 SHALL behave as set of an occupied slot, and SHALL never overflow count_o.
REQ-026 onehot_o SHALL hold its value until the next DECODE.

Reset
REQ-027 When rst_i is high at an edge:
- state SHALL become IDLE and cmd_ready_o=1
- onehot_o=0, valid_vec_o=0, count_o=0, done_o=0
- empty_o=1, full_o=0
REQ-028 Reset asserted in DECODE or COMMIT SHALL drop the in-flight command: no vector update and no done_o pulse.
REQ-029 Reset SHALL take priority over an accept occurring on the same edge.

Configuration
REQ-030 When the macro SLOT_DECODER_ERR_EN is defined, output err_o (1 bit) SHALL exist and SHALL be sticky.
- It SHALL be set at the COMMIT edge on: out-of-range index with op set or clear, set of an occupied slot, or clear of a free slot.
- It SHALL be cleared only by rst_i.
REQ-031 When SLOT_DECODER_ERR_EN is undefined, err_o and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then set idx 0, 5 and 31 -> valid_vec_o=32'h8000_0021, count_o=3, one done_o pulse per command, each exactly 3 cycles after its accept.
REQ-033 Hold cmd_valid_i high with a different index each cycle -> accepts occur only every third edge, and the captured index is the one present at each accept edge.
REQ-034 Set all 32 slots -> full_o=1 and count_o=32; then set idx 7 -> no change (err_o=1 with SLOT_DECODER_ERR_EN).
REQ-035 Send index 32 (miss code) with op set -> onehot_o=0, vector unchanged, done_o pulses; then clear-all -> onehot_o all ones, valid_vec_o=0, empty_o=1.
REQ-036 Accept set idx 3, then assert rst_i in COMMIT -> valid_vec_o=0, no done_o pulse, cmd_ready_o=1 on the next cycle.
